// File: rtl/purse_ctrl.sv
// Purse controller: accrues income on game ticks, clamps at the level's capacity,
// arbitrates unit purchases against purse upgrades, runs per-type cooldowns and
// hands accepted purchases to the spawner over a valid/ready handshake.
module purse_ctrl #(
    parameter int unsigned INCOME_BASE = 1,
    parameter int unsigned INCOME_STEP = 1,
    parameter int unsigned CD_TICKS    = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        buy_req,
    input  logic [2:0]  buy_type,
    input  logic [14:0] unit_cost,
    input  logic        upg_req,
    input  logic [14:0] need_money,
    input  logic [14:0] max_money,
    output logic [2:0]  level,
    output logic [14:0] money,
    output logic        buy_ack,
    output logic        buy_nack,
    output logic        upg_ack,
    output logic        upg_nack,
    output logic        spawn_valid,
    output logic [2:0]  spawn_type,
    input  logic        spawn_ready,
    output logic [7:0]  cd_busy
);

    typedef enum logic [0:0] {
        IDLE       = 1'b0,
        SPAWN_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] CD_LOAD = 8'(CD_TICKS);

    state_t      state_q, state_d;
    logic [14:0] money_q, money_d;
    logic [2:0]  level_q, level_d;
    logic        spawn_valid_q, spawn_valid_d;
    logic [2:0]  spawn_type_q, spawn_type_d;
    logic        buy_ack_q, buy_nack_q, upg_ack_q, upg_nack_q;
    logic [7:0]  cd_q [8];
    logic [7:0]  cd_d [8];
    logic [7:0]  cd_busy_q, cd_busy_d;

    // Arbitration results for this cycle
    logic        buy_ok;
    logic        upg_ok;
    logic [15:0] money16;
    logic [15:0] spend16;
    logic [15:0] inc16;
    logic [15:0] sum16;

    // A buy needs the spawner slot free, enough money and the type off cooldown.
    // An upgrade loses to any same-cycle buy request, accepted or not.
    always_comb begin
        buy_ok = buy_req && (state_q == IDLE) && (money_q >= unit_cost)
                 && (cd_q[buy_type] == 8'd0);
        upg_ok = upg_req && !buy_req && (level_q != 3'd7)
                 && (money_q >= need_money);
    end

    // Money update: spend first, then add income and clamp only on ticks.
    // Income and capacity both refer to the level before any upgrade this cycle.
    always_comb begin
        money16 = {1'b0, money_q};
        spend16 = 16'd0;
        if (buy_ok) begin
            spend16 = {1'b0, unit_cost};
        end else if (upg_ok) begin
            spend16 = {1'b0, need_money};
        end
        inc16   = 16'(INCOME_BASE) + 16'(level_q) * 16'(INCOME_STEP);
        sum16   = money16 - spend16;
        money_d = sum16[14:0];
        if (tick) begin
            sum16 = sum16 + inc16;
            if (sum16 > {1'b0, max_money}) begin
                money_d = max_money;
            end else begin
                money_d = sum16[14:0];
            end
        end
        level_d = upg_ok ? (level_q + 3'd1) : level_q;
    end

    // Per-type cooldown counters: a purchase reloads, otherwise ticks count down
    for (genvar gi = 0; gi < 8; gi++) begin : g_cd
        assign cd_d[gi] = (buy_ok && (buy_type == 3'(gi))) ? CD_LOAD :
                          (tick && (cd_q[gi] != 8'd0))      ? (cd_q[gi] - 8'd1) :
                                                              cd_q[gi];
        assign cd_busy_d[gi] = (cd_d[gi] != 8'd0);
    end

    // Spawner handshake FSM: one pending unit at most, type frozen while valid
    always_comb begin
        state_d       = state_q;
        spawn_valid_d = spawn_valid_q;
        spawn_type_d  = spawn_type_q;
        case (state_q)
            IDLE: begin
                if (buy_ok) begin
                    state_d       = SPAWN_WAIT;
                    spawn_valid_d = 1'b1;
                    spawn_type_d  = buy_type;
                end
            end
            SPAWN_WAIT: begin
                if (spawn_ready) begin
                    state_d       = IDLE;
                    spawn_valid_d = 1'b0;
                end
            end
            default: begin
                state_d       = IDLE;
                spawn_valid_d = 1'b0;
            end
        endcase
    end

    // State, purse and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            money_q       <= 15'd0;
            level_q       <= 3'd0;
            spawn_valid_q <= 1'b0;
            spawn_type_q  <= 3'd0;
            buy_ack_q     <= 1'b0;
            buy_nack_q    <= 1'b0;
            upg_ack_q     <= 1'b0;
            upg_nack_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            money_q       <= money_d;
            level_q       <= level_d;
            spawn_valid_q <= spawn_valid_d;
            spawn_type_q  <= spawn_type_d;
            buy_ack_q     <= buy_req && buy_ok;
            buy_nack_q    <= buy_req && !buy_ok;
            upg_ack_q     <= upg_req && upg_ok;
            upg_nack_q    <= upg_req && !upg_ok;
        end
    end

    // Cooldown counters with their busy flags registered alongside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                cd_q[i] <= 8'd0;
            end
            cd_busy_q <= 8'd0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                cd_q[i] <= cd_d[i];
            end
            cd_busy_q <= cd_busy_d;
        end
    end

    assign level       = level_q;
    assign money       = money_q;
    assign buy_ack     = buy_ack_q;
    assign buy_nack    = buy_nack_q;
    assign upg_ack     = upg_ack_q;
    assign upg_nack    = upg_nack_q;
    assign spawn_valid = spawn_valid_q;
    assign spawn_type  = spawn_type_q;
    assign cd_busy     = cd_busy_q;

endmodule

// File: tb/tb_purse_ctrl.sv
// Directed bench for purse_ctrl with a cycle-level reference model and a
// scoreboard queue of expected post-edge outputs.
module tb_purse_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic        buy_req;
    logic [2:0]  buy_type;
    logic [14:0] unit_cost;
    logic        upg_req;
    logic [14:0] need_money;
    logic [14:0] max_money;
    logic [2:0]  level;
    logic [14:0] money;
    logic        buy_ack, buy_nack, upg_ack, upg_nack;
    logic        spawn_valid;
    logic [2:0]  spawn_type;
    logic        spawn_ready;
    logic [7:0]  cd_busy;

    always #5 clk = ~clk;

    // Cost/purse tables as the top level would provide them
    assign unit_cost  = 15'(75 * (int'(buy_type) + 1));
    assign need_money = 15'(100 * (int'(level) + 1));
    assign max_money  = 15'(100 * (int'(level) + 1));

    purse_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .buy_req     (buy_req),
        .buy_type    (buy_type),
        .unit_cost   (unit_cost),
        .upg_req     (upg_req),
        .need_money  (need_money),
        .max_money   (max_money),
        .level       (level),
        .money       (money),
        .buy_ack     (buy_ack),
        .buy_nack    (buy_nack),
        .upg_ack     (upg_ack),
        .upg_nack    (upg_nack),
        .spawn_valid (spawn_valid),
        .spawn_type  (spawn_type),
        .spawn_ready (spawn_ready),
        .cd_busy     (cd_busy)
    );

    typedef struct {
        int money;
        int level;
        int bak;
        int bnk;
        int uak;
        int unk;
        int sv;
        int st;
        int cdb;
    } exp_t;

    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int m_money, m_level, m_valid, m_type;
    int m_cd[8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        m_money = 0;
        m_level = 0;
        m_valid = 0;
        m_type  = 0;
        for (int i = 0; i < 8; i++) m_cd[i] = 0;
    endtask

    // Async reset, checked before any clock edge can occur
    task automatic do_reset();
        rst_n = 1'b0;
        tick = 1'b0; buy_req = 1'b0; buy_type = 3'd0; upg_req = 1'b0; spawn_ready = 1'b0;
        #2;
        chk("rst_money", 32'(money), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_spawn_valid", 32'(spawn_valid), 0);
        chk("rst_spawn_type", 32'(spawn_type), 0);
        chk("rst_cd_busy", 32'(cd_busy), 0);
        chk("rst_acks", 32'({buy_ack, buy_nack, upg_ack, upg_nack}), 0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("reset applied");
    endtask

    // One clock of stimulus: model predicts, scoreboard holds, DUT is compared after the edge
    task automatic step(input bit t, input bit b, input int ty, input bit u, input bit r);
        exp_t e;
        int cost, need, maxm, busy;
        bit bok, uok;
        tick = t; buy_req = b; buy_type = 3'(ty); upg_req = u; spawn_ready = r;
        cost = 75 * (ty + 1);
        need = 100 * (m_level + 1);
        maxm = 100 * (m_level + 1);
        bok = b && (m_valid == 0) && (m_money >= cost) && (m_cd[ty] == 0);
        uok = u && !b && (m_level != 7) && (m_money >= need);
        if (bok) m_money -= cost;
        else if (uok) m_money -= need;
        if (t) begin
            m_money += 1 + m_level;
            if (m_money > maxm) m_money = maxm;
        end
        for (int i = 0; i < 8; i++) begin
            if (bok && ty == i) m_cd[i] = 30;
            else if (t && m_cd[i] > 0) m_cd[i]--;
        end
        if (m_valid == 0) begin
            if (bok) begin
                m_valid = 1;
                m_type  = ty;
            end
        end else if (r) begin
            m_valid = 0;
        end
        if (uok) m_level++;
        busy = 0;
        for (int i = 0; i < 8; i++) if (m_cd[i] != 0) busy |= (1 << i);
        e.money = m_money; e.level = m_level;
        e.bak = (b && bok) ? 1 : 0; e.bnk = (b && !bok) ? 1 : 0;
        e.uak = (u && uok) ? 1 : 0; e.unk = (u && !uok) ? 1 : 0;
        e.sv = m_valid; e.st = m_type; e.cdb = busy;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("money", 32'(money), 32'(e.money));
        chk("level", 32'(level), 32'(e.level));
        chk("buy_ack", 32'(buy_ack), 32'(e.bak));
        chk("buy_nack", 32'(buy_nack), 32'(e.bnk));
        chk("upg_ack", 32'(upg_ack), 32'(e.uak));
        chk("upg_nack", 32'(upg_nack), 32'(e.unk));
        chk("spawn_valid", 32'(spawn_valid), 32'(e.sv));
        chk("spawn_type", 32'(spawn_type), 32'(e.st));
        chk("cd_busy", 32'(cd_busy), 32'(e.cdb));
        $display("step t=%0b buy=%0b type=%0d upg=%0b rdy=%0b -> money=%0d level=%0d ack=%0b%0b%0b%0b sv=%0b cd=%02h",
                 t, b, ty, u, r, money, level, buy_ack, buy_nack, upg_ack, upg_nack, spawn_valid, cd_busy);
    endtask

    initial begin
        do_reset();

        // Income climbs by one per tick and saturates at 100
        for (int i = 0; i < 120; i++) step(1, 0, 0, 0, 0);
        chk("sat_money", 32'(money), 100);
        chk("sat_level", 32'(level), 0);

        // Upgrade with exactly the price
        step(0, 0, 0, 1, 0);
        chk("upg_money", 32'(money), 0);
        chk("upg_level", 32'(level), 1);

        // Purchase accept/reject and spawner backpressure
        do_reset();
        for (int i = 0; i < 80; i++) step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("nack_money", 32'(money), 80);
        step(0, 1, 0, 0, 0);
        chk("buy_money", 32'(money), 5);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        chk("held_valid", 32'(spawn_valid), 1);
        step(0, 0, 0, 0, 1);
        chk("drop_valid", 32'(spawn_valid), 0);

        // Buy beats upgrade in the same tick cycle
        do_reset();
        for (int i = 0; i < 99; i++) step(1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0);
        chk("combo_money", 32'(money), 25);

        // Climb to level 7, then upgrade is refused
        do_reset();
        for (int l = 0; l < 7; l++) begin
            for (int i = 0; i < 100; i++) step(1, 0, 0, 0, 0);
            step(0, 0, 0, 1, 0);
        end
        chk("top_level", 32'(level), 7);
        for (int i = 0; i < 100; i++) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("top_upg_level", 32'(level), 7);

        // Cooldown blocks a repeat buy until 30 ticks have passed
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        chk("cd_nack_money", 32'(money), 725);
        for (int i = 0; i < 29; i++) step(1, 0, 0, 0, 0);
        chk("cd_still_busy", 32'(cd_busy[0]), 1);
        step(1, 0, 0, 0, 0);
        chk("cd_clear", 32'(cd_busy[0]), 0);
        step(0, 1, 0, 0, 0);
        chk("cd_rebuy_valid", 32'(spawn_valid), 1);

        // Asynchronous reset in SPAWN_WAIT with a cooldown running
        #1;
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
